lsu_wbu_sender: RTL

LSU pipeline stage that accepts one instruction at a time from the EXU over a valid/ready handshake. For loads and stores it performs the memory access over a request/response interface. It then presents the write-back payload to the WBU register file over the rd_valid/rd_ready handshake. It is the transmitting end of the LSU→WBU interface: one transaction in flight, no buffering beyond a single entry.

---
 rtl/lsu_wbu_sender_pkg.sv | 35 +++
 rtl/lsu_wbu_sender_load_align.sv | 33 +++
 rtl/lsu_wbu_sender.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lsu_wbu_sender_pkg.sv
// Shared definitions for the LSU -> WBU sender stage.
// Contents: RV32 major opcodes, load/store funct3 codes, the stage FSM state
// encoding and a helper that classifies memory-access opcodes.
package lsu_wbu_sender_pkg;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Load/store width codes (inst[14:12])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_SEND     = 2'd3
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_wbu_sender_load_align.sv
// Combinational load formatter: extracts and extends the addressed byte/half
// from the aligned memory word according to funct3.
// Ports: rdata (word at addr & ~3), offset (addr[1:0]), funct3 -> result.
module lsu_load_align
  import lsu_wbu_sender_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword selection uses only addr[1]; misaligned halves are not trapped.
  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_H:    result = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_HU:   result = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: result = rdata; // lw and undefined widths: whole word
    endcase
  end

endmodule

// File: rtl/lsu_wbu_sender.sv
// LSU stage: takes one instruction from the EXU, performs the load/store if
// needed, then hands the write-back payload to the WBU. Single entry, no queue.
// Ports: exu_* (valid/ready in), mem_req_*/mem_rsp_* (memory), rd_* + payload (to WBU).
module lsu_wbu_sender
  import lsu_wbu_sender_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WIDTH  = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    exu_valid,
  output logic                    exu_ready,
  input  logic [DATA_WIDTH-1:0]   exu_inst,
  input  logic [DATA_WIDTH-1:0]   exu_result,
  input  logic [DATA_WIDTH-1:0]   exu_store_data,
  input  logic [DATA_WIDTH-1:0]   exu_next_pc,
  input  logic [NUM_WIDTH-1:0]    exu_num,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   lsu_to_wbu_inst,
  output logic [DATA_WIDTH-1:0]   next_pc,
  output logic [NUM_WIDTH-1:0]    num,
  output logic [DATA_WIDTH-1:0]   sim_lsu_addr
);

  localparam int MASK_W = DATA_WIDTH / 8;

  lsu_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] inst_q, addr_q, store_data_q, next_pc_q, wdata_q;
  logic [NUM_WIDTH-1:0]  num_q;
  logic [DATA_WIDTH-1:0] load_result;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store;

  assign opcode   = inst_q[6:0];
  assign funct3   = inst_q[14:12];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Responses are only honoured in MEM_WAIT, so a response
  // coincident with the request handshake is deliberately dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (exu_valid) state_d = is_mem_op(exu_inst[6:0]) ? ST_MEM_REQ : ST_SEND;
      ST_MEM_REQ:  if (mem_req_ready) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_rsp_valid) state_d = ST_SEND;
      ST_SEND:     if (rd_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    exu_ready     = (state_q == ST_IDLE);
    mem_req_valid = (state_q == ST_MEM_REQ);
    rd_valid      = (state_q == ST_SEND);
  end

  // Latched transaction fields; wdata starts as the ALU result and is only
  // overwritten by load data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_q       <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      next_pc_q    <= '0;
      num_q        <= '0;
      wdata_q      <= '0;
    end else if (state_q == ST_IDLE && exu_valid) begin
      inst_q       <= exu_inst;
      addr_q       <= exu_result;
      store_data_q <= exu_store_data;
      next_pc_q    <= exu_next_pc;
      num_q        <= exu_num;
      wdata_q      <= exu_result;
    end else if (state_q == ST_MEM_WAIT && mem_rsp_valid && is_load) begin
      wdata_q      <= load_result;
    end
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3),
    .result (load_result)
  );

  // Store lane steering: narrow data is replicated across the word so the
  // mask alone selects the written lane.
  always_comb begin
    mem_wmask = '0;
    mem_wdata = '0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          mem_wmask = {{(MASK_W-1){1'b0}}, 1'b1} << addr_q[1:0];
          mem_wdata = {MASK_W{store_data_q[7:0]}};
        end
        F3_H: begin
          mem_wmask = {{(MASK_W-2){1'b0}}, 2'b11} << {addr_q[1], 1'b0};
          mem_wdata = {(MASK_W/2){store_data_q[15:0]}};
        end
        default: begin
          mem_wmask = '1;
          mem_wdata = store_data_q;
        end
      endcase
    end
  end

  assign mem_addr        = addr_q;
  assign mem_wen         = is_store;
  assign wdata           = wdata_q;
  assign lsu_to_wbu_inst = inst_q;
  assign next_pc         = next_pc_q;
  assign num             = num_q;
  assign sim_lsu_addr    = (is_load || is_store) ? addr_q : '0;

endmodule
